// File: rtl/uart_cmd_ctrl.sv
// Command-frame controller: hunts SYNC/ADDR/DATA/CHK frames in the UART byte stream
// and issues one valid/ready register write per frame whose checksum matches.
module uart_cmd_ctrl #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_wr_valid,
  input  logic       i_wr_ready,
  output logic       o_busy,
  output logic       o_chk_err,
  output logic       o_tmo_err,
  output logic       o_ovr_err,
  output logic [7:0] o_err_count
);

  localparam int unsigned TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  // The timer holds clocks elapsed since the last accepted byte minus one, so the
  // (TIMEOUT_CLKS-1)th clock after that byte is the cycle where it equals TIMEOUT_CLKS-2.
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 2);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StChk,
    StWrite
  } state_e;

  state_e          r_state, w_state_d;
  logic [TW-1:0]   r_timer, w_timer_d;
  logic [7:0]      r_addr, w_addr_d;
  logic [7:0]      r_data, w_data_d;
  logic [7:0]      r_wr_addr, w_wr_addr_d;
  logic [7:0]      r_wr_data, w_wr_data_d;
  logic            r_chk_err, w_chk_err_d;
  logic            r_tmo_err, w_tmo_err_d;
  logic            r_ovr_err, w_ovr_err_d;
  logic [7:0]      r_err_count, w_err_count_d;
  logic            w_expire;
  logic            w_any_err;

  assign w_expire = (r_timer == TIMER_LAST);

  always_comb begin
    w_state_d   = r_state;
    w_timer_d   = '0;
    w_addr_d    = r_addr;
    w_data_d    = r_data;
    w_wr_addr_d = r_wr_addr;
    w_wr_data_d = r_wr_data;
    w_chk_err_d = 1'b0;
    w_tmo_err_d = 1'b0;
    w_ovr_err_d = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_rx_done && (i_rx_data == SYNC_BYTE)) begin
          w_state_d = StAddr;
        end
      end
      StAddr, StData, StChk: begin
        if (i_rx_done) begin
          if (r_state == StAddr) begin
            w_addr_d  = i_rx_data;
            w_state_d = StData;
          end else if (r_state == StData) begin
            w_data_d  = i_rx_data;
            w_state_d = StChk;
          end else if (i_rx_data == (r_addr ^ r_data)) begin
            w_wr_addr_d = r_addr;
            w_wr_data_d = r_data;
            w_state_d   = StWrite;
          end else begin
            w_chk_err_d = 1'b1;
            w_state_d   = StIdle;
          end
        end else if (w_expire) begin
          w_tmo_err_d = 1'b1;
          w_state_d   = StIdle;
        end else begin
          w_timer_d = r_timer + TW'(1);
        end
      end
      StWrite: begin
        // Any byte arriving while a write is pending is lost, even on the handshake cycle.
        w_ovr_err_d = i_rx_done;
        if (i_wr_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_any_err     = w_chk_err_d | w_tmo_err_d | w_ovr_err_d;
  assign w_err_count_d = (w_any_err && (r_err_count != 8'hFF)) ? r_err_count + 8'd1 : r_err_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_timer     <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_chk_err   <= 1'b0;
      r_tmo_err   <= 1'b0;
      r_ovr_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_d;
      r_timer     <= w_timer_d;
      r_addr      <= w_addr_d;
      r_data      <= w_data_d;
      r_wr_addr   <= w_wr_addr_d;
      r_wr_data   <= w_wr_data_d;
      r_chk_err   <= w_chk_err_d;
      r_tmo_err   <= w_tmo_err_d;
      r_ovr_err   <= w_ovr_err_d;
      r_err_count <= w_err_count_d;
    end
  end

  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_wr_valid  = (r_state == StWrite);
  assign o_busy      = (r_state != StIdle);
  assign o_chk_err   = r_chk_err;
  assign o_tmo_err   = r_tmo_err;
  assign o_ovr_err   = r_ovr_err;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed frame scenarios plus randomized traffic,
// every cycle compared against a byte-collecting reference model.
module tb_uart_cmd_ctrl;

  localparam int unsigned T    = 100;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       busy;
  logic       chk_err;
  logic       tmo_err;
  logic       ovr_err;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(
    .SYNC_BYTE   (SYNC),
    .TIMEOUT_CLKS(T)
  ) u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx_data  (rx_data),
    .i_rx_done  (rx_done),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_wr_valid (wr_valid),
    .i_wr_ready (wr_ready),
    .o_busy     (busy),
    .o_chk_err  (chk_err),
    .o_tmo_err  (tmo_err),
    .o_ovr_err  (ovr_err),
    .o_err_count(err_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a list of bytes collected after SYNC, a pending-write flag,
  // a count of silent clocks and the resulting observable values.
  logic [7:0] m_frame[$];
  bit         m_in_frame;
  bit         m_pend;
  int         m_silent;
  logic [7:0] m_wa, m_wd;
  bit         m_chk, m_tmo, m_ovr;
  int         m_errs;

  function automatic void model_reset();
    m_frame.delete();
    m_in_frame = 0;
    m_pend     = 0;
    m_silent   = 0;
    m_wa       = 8'h00;
    m_wd       = 8'h00;
    m_chk      = 0;
    m_tmo      = 0;
    m_ovr      = 0;
    m_errs     = 0;
  endfunction

  function automatic void model_step(input bit rd, input logic [7:0] d, input bit rdy);
    m_chk = 0;
    m_tmo = 0;
    m_ovr = 0;
    if (m_pend) begin
      if (rd) m_ovr = 1;
      if (rdy) m_pend = 0;
    end else if (!m_in_frame) begin
      if (rd && d == SYNC) begin
        m_in_frame = 1;
        m_frame.delete();
        m_silent = 0;
      end
    end else if (rd) begin
      m_silent = 0;
      if (m_frame.size() < 2) begin
        m_frame.push_back(d);
      end else begin
        m_in_frame = 0;
        if ((m_frame[0] ^ m_frame[1]) == d) begin
          m_pend = 1;
          m_wa   = m_frame[0];
          m_wd   = m_frame[1];
        end else begin
          m_chk = 1;
        end
      end
    end else begin
      m_silent++;
      if (m_silent == int'(T) - 1) begin
        m_tmo      = 1;
        m_in_frame = 0;
      end
    end
    if ((m_chk || m_tmo || m_ovr) && m_errs < 255) m_errs++;
  endfunction

  task automatic compare_all();
    check_eq("wr_valid", {31'd0, wr_valid}, {31'd0, m_pend});
    check_eq("wr_addr", {24'd0, wr_addr}, {24'd0, m_wa});
    check_eq("wr_data", {24'd0, wr_data}, {24'd0, m_wd});
    check_eq("busy", {31'd0, busy}, {31'd0, (m_in_frame || m_pend)});
    check_eq("chk_err", {31'd0, chk_err}, {31'd0, m_chk});
    check_eq("tmo_err", {31'd0, tmo_err}, {31'd0, m_tmo});
    check_eq("ovr_err", {31'd0, ovr_err}, {31'd0, m_ovr});
    check_eq("err_count", {24'd0, err_count}, m_errs);
  endtask

  bit rand_ready = 0;

  // One clock: drive inputs just after an edge, predict, then compare after the next edge.
  task automatic cycle(input bit rd, input logic [7:0] d);
    if (rand_ready) wr_ready = ($urandom_range(0, 2) != 0);
    rx_done = rd;
    rx_data = d;
    model_step(rd, d, wr_ready);
    @(posedge clk);
    #1;
    compare_all();
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c,
                       input int gap);
    send(SYNC);
    quiet(gap);
    send(a);
    quiet(gap);
    send(d);
    quiet(gap);
    send(c);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check_eq("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check_eq("rst_err_count", {24'd0, err_count}, 32'd0);
    check_eq("rst_pulses", {29'd0, chk_err, tmo_err, ovr_err}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 8'h00);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_done  = 1'b0;
    rx_data  = 8'h00;
    wr_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    quiet(2);

    // Basic write, bad checksum then recovery, hunting past noise.
    frame(8'h12, 8'h34, 8'h26, 0);
    quiet(3);
    frame(8'h12, 8'h34, 8'h00, 0);
    quiet(2);
    frame(8'h01, 8'h02, 8'h03, 1);
    quiet(2);
    send(8'h00); send(8'hFF); send(8'h5A); send(SYNC);
    send(8'h7F); send(8'h80); send(8'hFF);
    quiet(2);

    // Timeout, then a byte landing exactly in the expiry cycle.
    send(SYNC); send(8'h12);
    quiet(105);
    send(SYNC); send(8'h12);
    quiet(int'(T) - 2);
    send(8'h34); send(8'h26);
    quiet(2);
    // A failing SYNC-valued checksum must not restart the frame.
    frame(8'h00, 8'h01, SYNC, 0);
    send(8'h01); send(8'h02); send(8'h03);
    quiet(2);

    // Backpressure with an overrun byte during the stall.
    wr_ready = 1'b0;
    frame(8'h10, 8'h20, 8'h30, 0);
    quiet(5);
    send(8'h55);
    quiet(14);
    wr_ready = 1'b1;
    cycle(1'b0, 8'h00);
    quiet(2);
    // Overrun byte coinciding with the handshake.
    frame(8'h44, 8'h55, 8'h11, 0);
    send(8'h99);
    quiet(2);

    // Reset mid-frame and mid-write.
    send(SYNC); send(8'h12);
    do_reset();
    frame(8'h12, 8'h34, 8'h26, 0);
    quiet(2);
    wr_ready = 1'b0;
    frame(8'h21, 8'h43, 8'h62, 0);
    quiet(3);
    do_reset();
    wr_ready = 1'b1;
    quiet(2);

    // Saturation.
    for (int i = 0; i < 260; i++) begin
      frame(8'(i), 8'(i + 1), ~(8'(i) ^ 8'(i + 1)), 0);
    end
    quiet(2);
    frame(8'h05, 8'h06, 8'h00, 0);
    quiet(2);
    do_reset();

    // Randomized traffic with random backpressure and gaps.
    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      int kind;
      int gap;
      logic [7:0] a, d, c;
      kind = int'($urandom_range(0, 9));
      gap  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(int'(T) - 3, int'(T) + 1))
                                          : int'($urandom_range(0, 3));
      a = 8'($urandom);
      d = 8'($urandom);
      c = (kind < 6) ? (a ^ d) : 8'($urandom);
      if (kind == 9) begin
        send(8'($urandom));
      end else begin
        frame(a, d, c, gap);
      end
      quiet(int'($urandom_range(0, 4)));
    end
    rand_ready = 0;
    wr_ready   = 1'b1;
    quiet(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
